// File: rtl/gpio_cfg_serial_tx.sv
// Bit-serial transmitter for the daisy-chained pad configuration blocks.
// Optional chain readback is enabled with `define GPIO_CFG_READBACK_EN.
module gpio_cfg_serial_tx #(
    parameter int unsigned TOTAL_PADS = 38,
    parameter int unsigned CFG_BITS   = 13,
    parameter int unsigned CLK_DIV    = 2
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_i,
    input  logic [TOTAL_PADS*CFG_BITS-1:0]   cfg_data,
    input  logic                             start,
`ifdef GPIO_CFG_READBACK_EN
    input  logic                             serial_return,
    output logic [TOTAL_PADS*CFG_BITS-1:0]   rb_data,
    output logic                             rb_valid,
`endif
    output logic                             busy,
    output logic                             done,
    output logic                             serial_clock,
    output logic                             serial_data,
    output logic                             serial_load
);

    localparam int unsigned NB  = TOTAL_PADS * CFG_BITS;
    localparam int unsigned BCW = $clog2(NB + 1);
    localparam int unsigned PCW = $clog2(CLK_DIV + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(NB);
    localparam logic [PCW-1:0] PH_LAST  = PCW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LOAD,
        ST_DONE
    } state_e;

    state_e          state_q, state_d;
    logic [PCW-1:0]  phase_q, phase_d;
    logic [BCW-1:0]  bit_q, bit_d;
    logic [NB-1:0]   shreg_q, shreg_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            sclk_q, sclk_d;
    logic            sdata_q, sdata_d;
    logic            load_q, load_d;
    logic            phase_last;
    logic [BCW-1:0]  bit_inc;

`ifdef GPIO_CFG_READBACK_EN
    logic [NB-1:0]   rb_shift_q, rb_shift_d;
    logic [NB-1:0]   rb_data_q, rb_data_d;
    logic            rb_valid_q, rb_valid_d;
`endif

    // Next-state, counters and registered-output values
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        phase_last = (phase_q == PH_LAST);
        bit_inc    = bit_q + 1'b1;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    shreg_d = cfg_data;
                    phase_d = '0;
                    bit_d   = '0;
                    state_d = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                if (phase_last) begin
                    phase_d = '0;
                    state_d = ST_SHIFT_HI;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_SHIFT_HI: begin
                if (phase_last) begin
                    phase_d = '0;
                    bit_d   = bit_inc;
                    if (bit_inc == BIT_LAST) begin
                        state_d = ST_LOAD;
                    end else begin
                        shreg_d = shreg_q << 1;
                        state_d = ST_SHIFT_LO;
                    end
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_LOAD: begin
                if (phase_last) begin
                    phase_d = '0;
                    state_d = ST_DONE;
                end else begin
                    phase_d = phase_q + 1'b1;
                end
            end
            ST_DONE: begin
                bit_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs follow the next state so they are glitch-free flops
        busy_d  = (state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI) || (state_d == ST_LOAD);
        sclk_d  = (state_d == ST_SHIFT_HI);
        load_d  = (state_d == ST_LOAD);
        done_d  = (state_d == ST_DONE);
        sdata_d = ((state_d == ST_SHIFT_LO) || (state_d == ST_SHIFT_HI)) ? shreg_d[NB-1] : 1'b0;
    end

`ifdef GPIO_CFG_READBACK_EN
    // Chain output is captured on the edge where serial_clock rises
    always_comb begin
        rb_shift_d = rb_shift_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        if ((state_q == ST_SHIFT_LO) && phase_last) begin
            rb_shift_d = (rb_shift_q << 1) | NB'(serial_return);
        end
        if (state_d == ST_DONE) begin
            rb_data_d  = rb_shift_q;
            rb_valid_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            rb_shift_q <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_shift_q <= rb_shift_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    assign rb_data  = rb_data_q;
    assign rb_valid = rb_valid_q;
`endif

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sclk_q  <= 1'b0;
            sdata_q <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sclk_q  <= sclk_d;
            sdata_q <= sdata_d;
            load_q  <= load_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign serial_clock = sclk_q;
    assign serial_data  = sdata_q;
    assign serial_load  = load_q;

endmodule

// File: tb/tb_gpio_cfg_serial_tx.sv
// Scoreboard bench: three transmitter configurations, each feeding a modelled pad chain.
module tb_gpio_cfg_serial_tx;

    localparam int unsigned MAXB = 494;
    localparam int unsigned NI   = 3;

    typedef struct {
        logic [MAXB-1:0] cfg;
        logic [MAXB-1:0] prev;
    } exp_t;

    logic            clk;
    logic            rst;
    logic [5:0]      cfg0, cfg1;
    logic [MAXB-1:0] cfg2;
    logic [NI-1:0]   start_v, busy_v, done_v, sclk_v, sdat_v, load_v;
`ifdef GPIO_CFG_READBACK_EN
    logic [NI-1:0]   sret_v, rbv_v;
    logic [5:0]      rb0, rb1;
    logic [MAXB-1:0] rb2;
`endif

    int tests = 0;
    int fails = 0;

    // Monitor / chain model state
    logic [MAXB-1:0] chain_m [NI];
    logic [MAXB-1:0] latched [NI];
    logic            prev_sclk [NI], prev_sdat [NI], prev_load [NI], prev_done [NI], prev_busy [NI];
    int              busy_cnt [NI], load_cnt [NI], hi_run [NI], lo_run [NI];
    int              phase_err [NI], stab_err [NI], rises [NI];
    exp_t            exp_q [NI][$];
    logic [MAXB-1:0] preload_val;
    int              preload_seq = 0;
    int              preload_seen = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    gpio_cfg_serial_tx #(.TOTAL_PADS(2), .CFG_BITS(3), .CLK_DIV(1)) u_dut0 (
        .wb_clk_i(clk), .wb_rst_i(rst), .cfg_data(cfg0), .start(start_v[0]),
`ifdef GPIO_CFG_READBACK_EN
        .serial_return(sret_v[0]), .rb_data(rb0), .rb_valid(rbv_v[0]),
`endif
        .busy(busy_v[0]), .done(done_v[0]), .serial_clock(sclk_v[0]),
        .serial_data(sdat_v[0]), .serial_load(load_v[0])
    );

    gpio_cfg_serial_tx #(.TOTAL_PADS(2), .CFG_BITS(3), .CLK_DIV(3)) u_dut1 (
        .wb_clk_i(clk), .wb_rst_i(rst), .cfg_data(cfg1), .start(start_v[1]),
`ifdef GPIO_CFG_READBACK_EN
        .serial_return(sret_v[1]), .rb_data(rb1), .rb_valid(rbv_v[1]),
`endif
        .busy(busy_v[1]), .done(done_v[1]), .serial_clock(sclk_v[1]),
        .serial_data(sdat_v[1]), .serial_load(load_v[1])
    );

    gpio_cfg_serial_tx u_dut2 (
        .wb_clk_i(clk), .wb_rst_i(rst), .cfg_data(cfg2), .start(start_v[2]),
`ifdef GPIO_CFG_READBACK_EN
        .serial_return(sret_v[2]), .rb_data(rb2), .rb_valid(rbv_v[2]),
`endif
        .busy(busy_v[2]), .done(done_v[2]), .serial_clock(sclk_v[2]),
        .serial_data(sdat_v[2]), .serial_load(load_v[2])
    );

`ifdef GPIO_CFG_READBACK_EN
    assign sret_v[0] = chain_m[0][5];
    assign sret_v[1] = chain_m[1][5];
    assign sret_v[2] = chain_m[2][493];

    function automatic logic [MAXB-1:0] rb_of(input int k);
        case (k)
            0:       return MAXB'(rb0);
            1:       return MAXB'(rb1);
            default: return rb2;
        endcase
    endfunction
`endif

    function automatic int nb_of(input int k);
        return (k == 2) ? 494 : 6;
    endfunction

    function automatic int cb_of(input int k);
        return (k == 2) ? 13 : 3;
    endfunction

    function automatic int div_of(input int k);
        case (k)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [MAXB-1:0] lowmask(input int n);
        logic [MAXB-1:0] one;
        one = MAXB'(1);
        if (n >= int'(MAXB)) return '1;
        return (one << n) - one;
    endfunction

    function automatic logic [MAXB-1:0] rnd_vec(input int n);
        logic [MAXB-1:0] v;
        v = '0;
        for (int i = 0; i < int'(MAXB); i += 32) v = (v << 32) | MAXB'($urandom);
        return v & lowmask(n);
    endfunction

    task automatic chk(input string name, input logic [MAXB-1:0] act, input logic [MAXB-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_stats(input int k);
        busy_cnt[k]  = 0;
        load_cnt[k]  = 0;
        hi_run[k]    = 0;
        lo_run[k]    = 0;
        phase_err[k] = 0;
        stab_err[k]  = 0;
        rises[k]     = 0;
    endtask

    // Monitor: models the chain and checks each completed transfer against the scoreboard
    always @(negedge clk) begin
        for (int k = 0; k < int'(NI); k++) begin
            int   nb, d, cb, np;
            logic sc, sd, ld, bz, dn, rise, fall;
            exp_t e;
            nb = nb_of(k); d = div_of(k); cb = cb_of(k); np = nb / cb;
            sc = sclk_v[k]; sd = sdat_v[k]; ld = load_v[k]; bz = busy_v[k]; dn = done_v[k];
            if (rst) begin
                exp_q[k].delete();
                clear_stats(k);
                prev_sclk[k] = 1'b0; prev_sdat[k] = 1'b0; prev_load[k] = 1'b0;
                prev_done[k] = 1'b0; prev_busy[k] = 1'b0;
            end else begin
                if (k == 0 && preload_seq != preload_seen) begin
                    chain_m[0]   = preload_val;
                    preload_seen = preload_seq;
                end
                rise = sc && !prev_sclk[k];
                fall = !sc && prev_sclk[k];
                if (rise) begin
                    if (lo_run[k] != d) phase_err[k]++;
                    lo_run[k]  = 0;
                    chain_m[k] = ((chain_m[k] << 1) | MAXB'(sd)) & lowmask(nb);
                    rises[k]++;
                end
                if (fall) begin
                    if (hi_run[k] != d) phase_err[k]++;
                    hi_run[k] = 0;
                end
                if (sc) hi_run[k]++;
                else if (bz && !ld) lo_run[k]++;
                if (sd != prev_sdat[k] && !fall && !(bz && !prev_busy[k])) stab_err[k]++;
                if (ld && (sc || sd)) phase_err[k]++;
                if (bz) busy_cnt[k]++;
                if (ld) load_cnt[k]++;
                if (ld && !prev_load[k]) begin
                    latched[k] = chain_m[k];
                    if (exp_q[k].size() == 0)
                        chk($sformatf("u%0d spurious_load", k), MAXB'(ld), '0);
                end
`ifdef GPIO_CFG_READBACK_EN
                if (rbv_v[k] && !dn)
                    chk($sformatf("u%0d rb_valid_without_done", k), MAXB'(rbv_v[k]), '0);
`endif
                if (dn) begin
                    chk($sformatf("u%0d done_width", k), MAXB'(prev_done[k]), '0);
                    if (exp_q[k].size() == 0) begin
                        chk($sformatf("u%0d spurious_done", k), MAXB'(dn), '0);
                    end else begin
                        e = exp_q[k].pop_front();
                        for (int p = 0; p < np; p++)
                            chk($sformatf("u%0d pad%0d", k, p),
                                (latched[k] >> (p * cb)) & lowmask(cb),
                                (e.cfg >> (p * cb)) & lowmask(cb));
                        chk($sformatf("u%0d busy_len", k), MAXB'(busy_cnt[k]), MAXB'(nb * 2 * d + d));
                        chk($sformatf("u%0d load_len", k), MAXB'(load_cnt[k]), MAXB'(d));
                        chk($sformatf("u%0d phase_timing", k), MAXB'(phase_err[k]), '0);
                        chk($sformatf("u%0d data_stability", k), MAXB'(stab_err[k]), '0);
                        chk($sformatf("u%0d busy_at_done", k), MAXB'(bz), '0);
`ifdef GPIO_CFG_READBACK_EN
                        chk($sformatf("u%0d rb_valid", k), MAXB'(rbv_v[k]), MAXB'(1));
                        chk($sformatf("u%0d rb_data", k), rb_of(k), e.prev & lowmask(nb));
`endif
                    end
                    clear_stats(k);
                end
                prev_sclk[k] = sc; prev_sdat[k] = sd; prev_load[k] = ld;
                prev_done[k] = dn; prev_busy[k] = bz;
            end
        end
    end

    task automatic set_cfg(input int k, input logic [MAXB-1:0] v);
        case (k)
            0:       cfg0 = 6'(v);
            1:       cfg1 = 6'(v);
            default: cfg2 = v;
        endcase
    endtask

    task automatic send(input int k, input logic [MAXB-1:0] v);
        exp_t e;
        @(posedge clk); #1;
        set_cfg(k, v);
        start_v[k] = 1'b1;
        e.cfg  = v & lowmask(nb_of(k));
        e.prev = chain_m[k];
        exp_q[k].push_back(e);
        @(posedge clk); #1;
        start_v[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k, input int budget);
        int n;
        n = 0;
        while ((exp_q[k].size() != 0 || busy_v[k]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) begin
            tests++; fails++;
            $display("FAIL u%0d transfer_timeout: still busy after %0d cycles", k, n);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_zero(input int k, input string tag);
        chk($sformatf("u%0d %s outputs", k, tag),
            MAXB'({busy_v[k], done_v[k], sclk_v[k], sdat_v[k], load_v[k]}), '0);
`ifdef GPIO_CFG_READBACK_EN
        chk($sformatf("u%0d %s rb_valid", k, tag), MAXB'(rbv_v[k]), '0);
`endif
    endtask

    initial begin
        int n;
        rst = 1'b1; start_v = '0; cfg0 = '0; cfg1 = '0; cfg2 = '0; preload_val = '0;
        for (int k = 0; k < int'(NI); k++) begin
            chain_m[k] = '0;
            latched[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int k = 0; k < int'(NI); k++) check_zero(k, "reset");

        // Small chain, fast clock: directed pattern then random
        send(0, MAXB'(6'b101100));
        wait_idle(0, 100);
        for (int i = 0; i < 4; i++) begin
            send(0, rnd_vec(6));
            wait_idle(0, 100);
        end

        // Small chain, slow clock
        send(1, MAXB'(6'b101100));
        wait_idle(1, 200);
        for (int i = 0; i < 3; i++) begin
            send(1, rnd_vec(6));
            wait_idle(1, 200);
        end

        // Snapshot isolation and start ignored while busy
        send(0, MAXB'(6'b101100));
        cfg0 = 6'b111111;
        repeat (4) @(posedge clk);
        #1 start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        wait_idle(0, 100);
        repeat (20) @(negedge clk);
        chk("u0 no_second_transfer", MAXB'(busy_v[0]), '0);

        // Reset in the middle of a transfer
        send(0, MAXB'(6'b110101));
        n = 0;
        while (rises[0] < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++; fails++;
            $display("FAIL u0 bit3_timeout: rises=%0d", rises[0]);
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_zero(0, "abort");
        repeat (30) @(negedge clk);
        chk("u0 idle_after_abort", MAXB'({busy_v[0], load_v[0], done_v[0]}), '0);
        send(0, MAXB'(6'b011010));
        wait_idle(0, 100);

        // start during the done cycle is ignored
        send(1, rnd_vec(6));
        n = 0;
        while (!done_v[1] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            tests++; fails++;
            $display("FAIL u1 done_timeout: waited %0d cycles", n);
        end
        start_v[1] = 1'b1;
        @(posedge clk); #1 start_v[1] = 1'b0;
        repeat (5) @(negedge clk);
        chk("u1 start_in_done_ignored", MAXB'(busy_v[1]), '0);
        repeat (40) @(negedge clk);

        // Full-size chain with random configuration
        for (int i = 0; i < 2; i++) begin
            send(2, rnd_vec(494));
            wait_idle(2, 3000);
        end

`ifdef GPIO_CFG_READBACK_EN
        // Readback of previous chain contents
        preload_val = MAXB'(6'b010011);
        preload_seq++;
        repeat (2) @(negedge clk);
        send(0, MAXB'(6'b111000));
        wait_idle(0, 100);
        chk("u0 rb_data_hold", MAXB'(rb0), MAXB'(6'b010011));
        chk("u0 chain_after_rb", chain_m[0], MAXB'(6'b111000));
`endif

        for (int k = 0; k < int'(NI); k++)
            chk($sformatf("u%0d scoreboard_drained", k), MAXB'(exp_q[k].size()), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gpio_cfg_serial_tx.md
Name: gpio_cfg_serial_tx

Overview:
- Serial transmitter that shifts per-pad GPIO configuration words down the daisy-chained pad control blocks. The chain feeds the user-area pad array's dm/oeb/inp_dis/etc. controls.
- Sits in housekeeping, between the configuration register file and the first pad control block of the chain.
- Snapshots a flat configuration vector on start, shifts it out bit-serially with a generated serial clock, then pulses a load strobe to latch all pads at once.

Parameters:
- TOTAL_PADS, 38, number of pad control blocks in the chain
- CFG_BITS, 13, configuration bits per pad
- CLK_DIV, 2, wb_clk_i cycles per serial_clock phase (low and high each); legal range >=1

Ports:
- wb_clk_i  input  1  system clock; all logic on rising edge
- wb_rst_i  input  1  synchronous active-high reset
- cfg_data  input  TOTAL_PADS*CFG_BITS  flat config; pad p occupies [p*CFG_BITS +: CFG_BITS]
- start  input  1  one-cycle request to transmit cfg_data
- busy  output  1  transfer in progress (SHIFT or LOAD)
- done  output  1  one-cycle pulse on completion
- serial_clock  output  1  chain shift clock; receivers sample serial_data on its rising edge
- serial_data  output  1  chain data, MSB of cfg_data first
- serial_load  output  1  latch strobe to all pad control blocks

Behaviour:
- Reset: busy=0, done=0, serial_clock=0, serial_data=0, serial_load=0, state=IDLE, counters=0. Reset applies from any state, aborts mid-transfer, and never emits serial_load.
- NB = TOTAL_PADS*CFG_BITS. Bit counter width is clog2(NB+1). Phase counter width is clog2(CLK_DIV+1).
- States: IDLE, SHIFT_LO, SHIFT_HI, LOAD, DONE.
- IDLE, start=1:
  - Snapshot cfg_data into shift register.
  - Next cycle: state=SHIFT_LO, busy=1, serial_data=cfg_data[NB-1], serial_clock=0.
- IDLE, start=0: hold. start while busy=1 is ignored (no queuing). Snapshot makes later cfg_data changes invisible to the current transfer.
- SHIFT_LO:
  - serial_clock=0 for CLK_DIV cycles; serial_data stable.
  - Then go to SHIFT_HI.
- SHIFT_HI:
  - serial_clock=1 for CLK_DIV cycles; serial_data stable.
  - At exit, bit counter increments.
  - If counter < NB: shift left, present the next bit, return to SHIFT_LO. serial_data changes only in the cycle serial_clock falls.
  - If counter == NB: go to LOAD.
- LOAD: serial_clock=0, serial_data=0, serial_load=1 for CLK_DIV cycles, then DONE.
- DONE: busy=0, serial_load=0, done=1 for exactly one cycle, then IDLE. start in the DONE cycle is ignored.
- busy duration: exactly NB*2*CLK_DIV + CLK_DIV cycles.
- Chain ordering: the first bit shifted travels farthest. After load, pad TOTAL_PADS-1 holds cfg_data[NB-1 -: CFG_BITS] and pad 0 holds cfg_data[CFG_BITS-1:0].
- No glitches: all outputs are registered.

Optional Feature:
- Macro: GPIO_CFG_READBACK_EN.
- With the macro defined:
  - Adds input serial_return (1 bit, output end of the chain).
  - Adds output rb_data (NB bits) and output rb_valid (1 bit).
  - serial_return is sampled on each wb_clk_i cycle where serial_clock rises (last cycle of SHIFT_LO). It is shifted into rb_data LSB-first-in, so that after NB samples rb_data equals the chain contents prior to this transfer.
  - rb_valid pulses together with done. rb_data holds until the next completed transfer.
  - rb_data and rb_valid reset to 0.
  - An aborted transfer (reset) leaves rb_valid=0.
- Without the macro: those ports and registers do not exist; behaviour is otherwise identical.

Test Plan:
- Config TOTAL_PADS=2, CFG_BITS=3, CLK_DIV=1, cfg_data=6'b101100, start pulse:
  - serial_data bit sequence is 1,0,1,1,0,0, sampled at the 6 serial_clock rising edges.
  - busy is high for 13 cycles.
  - serial_load is high 1 cycle.
  - done pulses the cycle after.
- Same config, CLK_DIV=3:
  - Each serial_clock phase lasts 3 cycles.
  - busy lasts 39 cycles.
  - serial_data never changes while serial_clock=1.
- Start plus data change:
  - Pulse start, change cfg_data to all ones 1 cycle later, and pulse start again mid-transfer.
  - Shifted stream still matches the original snapshot; no second transfer occurs.
- Reset mid-transfer:
  - Assert wb_rst_i after bit 3.
  - Next cycle all outputs are 0; no serial_load or done ever follows; a fresh start afterwards transmits the full 6 bits correctly.
- Default parameters (38x13), random cfg_data, bench models a 494-bit chain:
  - After serial_load, each modelled pad register equals its cfg_data slice.
  - done is a single-cycle pulse.
- With GPIO_CFG_READBACK_EN:
  - Preload the chain model with 6'b010011 (small config) and transmit 6'b111000.
  - rb_valid pulses with done; rb_data=6'b010011; chain model then holds 6'b111000.
